// File: rtl/wb_cmd_master.sv
// Wishbone initiator: turns one local command into one classic Wishbone cycle
// and returns one response, aborting with an error if the slave never acknowledges.
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_stb,
    output logic        o_cmd_rdy,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_adr,
    input  logic [31:0] i_cmd_dat,
    input  logic [3:0]  i_cmd_sel,
    output logic        o_rsp_stb,
    output logic [31:0] o_rsp_dat,
    output logic        o_rsp_err,
    output logic        o_wbm_cyc,
    output logic        o_wbm_stb,
    output logic        o_wbm_we,
    output logic [31:0] o_wbm_adr,
    output logic [31:0] o_wbm_dat,
    output logic [3:0]  o_wbm_sel,
    input  logic        i_wbm_ack,
    input  logic [31:0] i_wbm_dat,
    input  logic        i_wbm_int,
    output logic        o_int
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              rdy_q, rdy_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              rsp_stb_q, rsp_stb_d;
    logic [31:0]       rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              int_q;

    logic accept;
    logic timeout;

    assign accept  = (state_q == S_IDLE) && i_cmd_stb;
    // Ack wins over a timeout landing on the same cycle.
    assign timeout = (state_q == S_BUS) && !i_wbm_ack && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_BUS;
            S_BUS:  if (i_wbm_ack || timeout) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdy_d     = (state_d == S_IDLE);
        cyc_d     = (state_d == S_BUS);
        rsp_stb_d = (state_d == S_RESP);
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d  = i_cmd_we;
                    adr_d = i_cmd_adr;
                    dat_d = i_cmd_dat;
                    sel_d = i_cmd_sel;
                    cnt_d = '0;
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_wbm_ack) begin
                    rsp_dat_d = we_q ? 32'h0 : i_wbm_dat;
                    rsp_err_d = 1'b0;
                end else if (timeout) begin
                    rsp_dat_d = 32'hFFFF_FFFF;
                    rsp_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q     <= 1'b1;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_stb_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            cnt_q     <= '0;
            int_q     <= 1'b0;
        end else begin
            rdy_q     <= rdy_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_stb_q <= rsp_stb_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            cnt_q     <= cnt_d;
            int_q     <= i_wbm_int;
        end
    end

    assign o_cmd_rdy = rdy_q;
    assign o_wbm_cyc = cyc_q;
    assign o_wbm_stb = cyc_q;
    assign o_wbm_we  = we_q;
    assign o_wbm_adr = adr_q;
    assign o_wbm_dat = dat_q;
    assign o_wbm_sel = sel_q;
    assign o_rsp_stb = rsp_stb_q;
    assign o_rsp_dat = rsp_dat_q;
    assign o_rsp_err = rsp_err_q;
    assign o_int     = int_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: directed commands against a configurable-latency slave.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_stb, o_cmd_rdy, i_cmd_we;
    logic [31:0] i_cmd_adr, i_cmd_dat;
    logic [3:0]  i_cmd_sel;
    logic        o_rsp_stb, o_rsp_err;
    logic [31:0] o_rsp_dat;
    logic        o_wbm_cyc, o_wbm_stb, o_wbm_we;
    logic [31:0] o_wbm_adr, o_wbm_dat;
    logic [3:0]  o_wbm_sel;
    logic        i_wbm_ack;
    logic [31:0] i_wbm_dat;
    logic        i_wbm_int, o_int;

    logic        slv_ack, spur_ack;
    assign i_wbm_ack = slv_ack | spur_ack;

    wb_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_stb(i_cmd_stb), .o_cmd_rdy(o_cmd_rdy), .i_cmd_we(i_cmd_we),
        .i_cmd_adr(i_cmd_adr), .i_cmd_dat(i_cmd_dat), .i_cmd_sel(i_cmd_sel),
        .o_rsp_stb(o_rsp_stb), .o_rsp_dat(o_rsp_dat), .o_rsp_err(o_rsp_err),
        .o_wbm_cyc(o_wbm_cyc), .o_wbm_stb(o_wbm_stb), .o_wbm_we(o_wbm_we),
        .o_wbm_adr(o_wbm_adr), .o_wbm_dat(o_wbm_dat), .o_wbm_sel(o_wbm_sel),
        .i_wbm_ack(i_wbm_ack), .i_wbm_dat(i_wbm_dat), .i_wbm_int(i_wbm_int),
        .o_int(o_int)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] dat; logic err; } rsp_t;
    typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; int len; } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Slave: acks in the (ack_wait+1)-th strobed cycle; ack_wait < 0 never acks.
    int          ack_wait = 0;
    logic [31:0] rd_key = 32'h0;
    int          idx = 0;
    initial begin
        slv_ack   = 1'b0;
        i_wbm_dat = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (o_wbm_cyc && o_wbm_stb) begin
                slv_ack   = (idx == ack_wait);
                i_wbm_dat = rd_key ^ o_wbm_adr;
                idx++;
            end else begin
                slv_ack = 1'b0;
                idx     = 0;
            end
        end
    end

    rsp_t r;
    bus_t e, cur;
    int   blen = 0;
    always @(negedge clk) begin
        if (o_rsp_stb) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_stb=1 dat=%h err=%b, required no response", o_rsp_dat, o_rsp_err);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_dat", o_rsp_dat, r.dat);
                chk("rsp_err", {31'h0, o_rsp_err}, {31'h0, r.err});
            end
        end
        if (o_wbm_cyc && o_wbm_stb) begin
            if (blen == 0) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus: got cyc/stb=1 adr=%h, required idle bus", o_wbm_adr);
                end else begin
                    e = bus_q[0];
                    chk("bus_we", {31'h0, o_wbm_we}, {31'h0, e.we});
                    chk("bus_adr", o_wbm_adr, e.adr);
                    chk("bus_dat", o_wbm_dat, e.dat);
                    chk("bus_sel", {28'h0, o_wbm_sel}, {28'h0, e.sel});
                end
                cur.we  = o_wbm_we;
                cur.adr = o_wbm_adr;
                cur.dat = o_wbm_dat;
                cur.sel = o_wbm_sel;
            end else begin
                chk("bus_stable", {o_wbm_adr ^ o_wbm_dat, 3'b0, o_wbm_we, o_wbm_sel, 24'h0},
                    {cur.adr ^ cur.dat, 3'b0, cur.we, cur.sel, 24'h0});
            end
            blen++;
        end else if (blen > 0) begin
            if (bus_q.size() > 0) begin
                e = bus_q.pop_front();
                chk("bus_len", 32'(blen), 32'(e.len));
            end
            blen = 0;
        end
    end

    task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int len, input logic [31:0] rdat,
                        input logic err, input bit want_rsp);
        bus_t b;
        rsp_t p;
        b.we = we; b.adr = adr; b.dat = dat; b.sel = sel; b.len = len;
        bus_q.push_back(b);
        if (want_rsp) begin
            p.dat = rdat;
            p.err = err;
            rsp_q.push_back(p);
        end
    endtask

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output int acc);
        int n = 0;
        i_cmd_we  = we;
        i_cmd_adr = adr;
        i_cmd_dat = dat;
        i_cmd_sel = sel;
        i_cmd_stb = 1'b1;
        forever begin
            @(negedge clk);
            if (o_cmd_rdy) break;
            n++;
            if (n > 50) begin
                chk("cmd_accept_timeout", {31'h0, o_cmd_rdy}, 32'h1);
                break;
            end
        end
        @(posedge clk);
        acc = cyc_cnt;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0 || !o_cmd_rdy) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", 32'(rsp_q.size() + bus_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    int a0, a1, a2, a3;
    initial begin
        rst = 1'b1; i_cmd_stb = 1'b0; i_cmd_we = 1'b0; i_cmd_adr = '0; i_cmd_dat = '0;
        i_cmd_sel = '0; i_wbm_int = 1'b0; spur_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", {31'h0, o_cmd_rdy}, 32'h1);
        chk("rst_rsp_stb", {31'h0, o_rsp_stb}, 32'h0);
        chk("rst_rsp_err", {31'h0, o_rsp_err}, 32'h0);
        chk("rst_rsp_dat", o_rsp_dat, 32'h0);
        chk("rst_cyc_stb", {30'h0, o_wbm_cyc, o_wbm_stb}, 32'h0);
        chk("rst_we", {31'h0, o_wbm_we}, 32'h0);
        chk("rst_adr", o_wbm_adr, 32'h0);
        chk("rst_dat", o_wbm_dat, 32'h0);
        chk("rst_sel", {28'h0, o_wbm_sel}, 32'h0);
        chk("rst_int", {31'h0, o_int}, 32'h0);
        rst = 1'b0;

        // Write with two wait states
        ack_wait = 2;
        push(1'b1, 32'h1, 32'hA5A5_0003, 4'hF, 3, 32'h0, 1'b0, 1'b1);
        send(1'b1, 32'h1, 32'hA5A5_0003, 4'hF, a0);
        i_cmd_stb = 1'b0;
        drain();

        // Zero-wait reads back to back: 3-cycle accept spacing
        ack_wait = 0;
        rd_key   = 32'h1234_5678;
        push(1'b0, 32'h0, 32'hDEAD_0000, 4'hF, 1, 32'h1234_5678, 1'b0, 1'b1);
        push(1'b0, 32'h4, 32'hDEAD_0004, 4'hF, 1, 32'h1234_567C, 1'b0, 1'b1);
        send(1'b0, 32'h0, 32'hDEAD_0000, 4'hF, a0);
        send(1'b0, 32'h4, 32'hDEAD_0004, 4'hF, a1);
        i_cmd_stb = 1'b0;
        chk("read_rdy_spacing", 32'(a1 - a0), 32'd3);
        drain();

        // Timeout, then a late ack that must be ignored
        ack_wait = -1;
        push(1'b0, 32'h40, 32'h0, 4'h3, 8, 32'hFFFF_FFFF, 1'b1, 1'b1);
        send(1'b0, 32'h40, 32'h0, 4'h3, a0);
        i_cmd_stb = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        spur_ack = 1'b1;
        @(posedge clk);
        #1;
        spur_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("late_ack_idle", {30'h0, o_cmd_rdy, o_wbm_cyc}, 32'h2);
        drain();

        // Ack on the last timeout cycle wins
        ack_wait = 7;
        rd_key   = 32'hCAFE_F00D;
        push(1'b0, 32'h80, 32'h0, 4'hF, 8, 32'hCAFE_F08D, 1'b0, 1'b1);
        send(1'b0, 32'h80, 32'h0, 4'hF, a0);
        i_cmd_stb = 1'b0;
        drain();

        // Four commands with i_cmd_stb held throughout
        ack_wait = 0;
        rd_key   = 32'h0F0F_0F0F;
        push(1'b1, 32'h100, 32'h1111_1111, 4'h1, 1, 32'h0, 1'b0, 1'b1);
        push(1'b0, 32'h104, 32'h2222_2222, 4'hF, 1, 32'h0F0F_0E0B, 1'b0, 1'b1);
        push(1'b1, 32'h108, 32'h3333_3333, 4'h3, 1, 32'h0, 1'b0, 1'b1);
        push(1'b0, 32'h10C, 32'h4444_4444, 4'hC, 1, 32'h0F0F_0E03, 1'b0, 1'b1);
        send(1'b1, 32'h100, 32'h1111_1111, 4'h1, a0);
        send(1'b0, 32'h104, 32'h2222_2222, 4'hF, a1);
        send(1'b1, 32'h108, 32'h3333_3333, 4'h3, a2);
        send(1'b0, 32'h10C, 32'h4444_4444, 4'hC, a3);
        i_cmd_stb = 1'b0;
        chk("b2b_spacing_1", 32'(a1 - a0), 32'd3);
        chk("b2b_spacing_2", 32'(a2 - a1), 32'd3);
        chk("b2b_spacing_3", 32'(a3 - a2), 32'd3);
        drain();

        // Reset in the middle of a bus cycle
        ack_wait = -1;
        push(1'b1, 32'h200, 32'h55AA_55AA, 4'hF, 3, 32'h0, 1'b0, 1'b0);
        send(1'b1, 32'h200, 32'h55AA_55AA, 4'hF, a0);
        i_cmd_stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_cyc_stb", {30'h0, o_wbm_cyc, o_wbm_stb}, 32'h0);
        chk("mid_rst_rdy", {31'h0, o_cmd_rdy}, 32'h1);
        repeat (12) @(posedge clk);
        #1;
        ack_wait = 1;
        push(1'b1, 32'h204, 32'h0BAD_F00D, 4'h5, 2, 32'h0, 1'b0, 1'b1);
        send(1'b1, 32'h204, 32'h0BAD_F00D, 4'h5, a0);
        i_cmd_stb = 1'b0;
        drain();

        // Interrupt passes through one register
        i_wbm_int = 1'b1;
        @(negedge clk);
        chk("int_rise_delay", {31'h0, o_int}, 32'h0);
        @(posedge clk);
        #1;
        chk("int_rise", {31'h0, o_int}, 32'h1);
        i_wbm_int = 1'b0;
        @(negedge clk);
        chk("int_fall_delay", {31'h0, o_int}, 32'h1);
        @(posedge clk);
        #1;
        chk("int_fall", {31'h0, o_int}, 32'h0);

        repeat (5) @(posedge clk);
        #1;
        chk("end_queues_empty", 32'(rsp_q.size() + bus_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
